mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Shared iterative multiply unit with round-robin arbitration across the cores' EX stages. A core holds `req` while its EX stage carries a MUL; the block grants one requester, runs a shift-add multiply over `DATA_W` cycles and returns the low `DATA_W` product bits with a one-cycle `done` pulse. The requesting EX stage stalls until its `done` bit is seen. Core flush aborts an in-flight operation.

## Interface
- `NCORES`, default 4: number of requesting cores, ≥2.
- `DATA_W`, default `` `DATA_W `` (32): operand/result width.
- `IDX_W`, default `$clog2(NCORES)`: owner index width.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  NCORES  per-core level request; held until own `done` bit.
- `flush`  in  NCORES  per-core flush of the EX stage.
- `arg_a`  in  NCORES*DATA_W  multiplicands; core i at `[i*DATA_W +: DATA_W]`.
- `arg_b`  in  NCORES*DATA_W  multipliers; same packing.
- `gnt`  out  NCORES  one-hot owner of the unit; zero in IDLE.
- `busy`  out  1  unit in RUN or DONE.
- `done`  out  NCORES  one-hot, one-cycle completion pulse to owner.
- `res`  out  DATA_W  product low half; valid only while `done` is nonzero.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: effective request `req & ~flush`. If nonzero, pick the first set bit searching upward from `last+1` (mod NCORES). On the clock edge:
  - latch `owner` and `last`;
  - load `mcand = arg_a[owner]`, `mplier = arg_b[owner]`, `acc = 0`, `cnt = 0`;
  - go to RUN.
- RUN, each cycle:
  - if `mplier[0]`, `acc += mcand`;
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`;
  - go to DONE after the cycle where `cnt == DATA_W-1`.
- Arithmetic: all modulo 2^DATA_W; overflow discarded. The low half is identical for signed and unsigned operands.
- DONE: `done[owner] = 1`, `res = acc`, then go to IDLE.
- `gnt[owner] = 1` in RUN and DONE.
- `flush[owner]` in RUN or DONE: go to IDLE on that edge; `done` is forced to 0 that cycle. Flush wins over final RUN cycle and DONE.
- Flush of a non-owner: no effect on the running operation. A flushed core is not granted in IDLE.
- Input changes to `arg_a`/`arg_b` after grant are ignored.
- Reset (any state, mid-operation included):
  - state = IDLE, `acc`/`res` = 0, `done` = 0, `gnt` = 0, `busy` = 0;
  - `last = NCORES-1`, so core 0 has first priority.

## Timing
- Request high in IDLE at cycle t: `gnt` from t+1, RUN t+1..t+DATA_W, `done`/`res` at t+DATA_W+1, IDLE at t+DATA_W+2.
- A new grant is possible at t+DATA_W+2 → issue interval DATA_W+2 cycles.
- The owner sees `done` in cycle d and advances its pipeline at that edge. `req` at d+1 is therefore a new request and is eligible for arbitration.
- Waiting requesters stay pending with no timeout. Round-robin bounds the wait to (NCORES-1) operations.
- `done`, `res`, `gnt` and `busy` are decoded from registered state; there is no combinational path from `req`.

## Configuration
- `MUL_EARLY_EXIT_EN`, defined: in RUN, if `mplier == 0` at cycle start, no accumulate occurs and the FSM moves to DONE on that edge. RUN also ends at `cnt == DATA_W-1`, as without the macro.
  - `arg_b = 0`: `done` at t+2.
  - Otherwise, `done` at t+msb(b)+3, capped at t+DATA_W+1.
- `MUL_EARLY_EXIT_EN`, undefined: fixed latency per Timing; `mplier` is not compared.

## Test plan
- Reset, then core 1 requests with a=7, b=6: `gnt = 0010` at t+1, `done = 0010` with `res = 42` at t+33 (DATA_W=32), IDLE at t+34.
- Cores 0, 2, 3 request simultaneously and continuously after reset: service order 0, 2, 3, 0. Each `done` is one-hot, and consecutive `done` pulses are 34 cycles apart.
- a=0xFFFFFFFF, b=0xFFFFFFFF → `res = 0x00000001`. a=0x80000000, b=2 → `res = 0`.
- `flush[owner]` asserted at t+10, with core 2 also requesting: no `done` for the owner, IDLE at t+11, core 2 granted at t+12.
- `rst` pulsed at t+5 of an operation: all outputs 0 the next cycle. The following simultaneous requests from cores 0 and 3 grant core 0.
- With `MUL_EARLY_EXIT_EN`: b=0 → `done` at t+2 with `res = 0`. b=3, a=5 → `done` at t+4 with `res = 15`.

Source files
------------

// File: rtl/mul_arbiter.sv
//==============================================================================
// Module   : mul_arbiter
// Purpose  : Shared shift-add multiplier with round-robin arbitration across
//            core EX stages; returns the low DATA_W product bits.
// Options  : MUL_EARLY_EXIT_EN - finish RUN as soon as the multiplier empties.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef DATA_W
`define DATA_W 32
`endif

module mul_arbiter #(
    parameter int NCORES = 4,
    parameter int DATA_W = `DATA_W,
    parameter int IDX_W  = $clog2(NCORES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        req,
    input  logic [NCORES-1:0]        flush,
    input  logic [NCORES*DATA_W-1:0] arg_a,
    input  logic [NCORES*DATA_W-1:0] arg_b,
    output logic [NCORES-1:0]        gnt,
    output logic                     busy,
    output logic [NCORES-1:0]        done,
    output logic [DATA_W-1:0]        res
);

    localparam int               CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic               w_pick_vld;
    logic [NCORES-1:0]  w_eff_req;
    logic [NCORES-1:0]  w_owner_oh;
    logic               w_owner_flush;
    logic               w_last_step;
    logic               w_done_vld;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;
    logic [CNT_W-1:0]   r_cnt;

    // A core whose EX stage is being flushed must not win arbitration.
    assign w_eff_req = req & ~flush;

    // Descending scan so the closest candidate after r_last is assigned last.
    always_comb begin
        w_pick     = r_last;
        w_pick_vld = 1'b0;
        w_idx      = '0;
        for (int k = NCORES; k >= 1; k--) begin
            w_idx = IDX_W'((32'(r_last) + 32'(k)) % 32'(NCORES));
            if (w_eff_req[w_idx]) begin
                w_pick     = w_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_sel_a = arg_a[i*DATA_W +: DATA_W];
                w_sel_b = arg_b[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_owner_oh
            assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
        end
    endgenerate

    assign w_owner_flush = |(flush & w_owner_oh);

`ifdef MUL_EARLY_EXIT_EN
    assign w_last_step = (r_cnt == C_CNT_LAST) || (r_mplier == '0);
`else
    assign w_last_step = (r_cnt == C_CNT_LAST);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_owner_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_last   <= IDX_W'(NCORES - 1);
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_owner  <= w_pick;
                        r_last   <= w_pick;
                        r_mcand  <= w_sel_a;
                        r_mplier <= w_sel_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    // An empty multiplier has bit 0 clear, so early exit adds nothing.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign gnt        = busy ? w_owner_oh : '0;
    assign w_done_vld = (r_state == S_DONE) && !w_owner_flush;
    assign done       = w_done_vld ? w_owner_oh : '0;
    assign res        = w_done_vld ? r_acc : '0;

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
//==============================================================================
// Module   : tb_mul_arbiter
// Purpose  : Directed self-checking bench for mul_arbiter (NCORES=4, DATA_W=32).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul_arbiter;

    localparam int NC = 4;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NC-1:0]      req = '0;
    logic [NC-1:0]      flush = '0;
    logic [NC*DW-1:0]   arg_a = '0;
    logic [NC*DW-1:0]   arg_b = '0;
    logic [NC-1:0]      gnt;
    logic               busy;
    logic [NC-1:0]      done;
    logic [DW-1:0]      res;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          core;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t tv[8];

    mul_arbiter #(.NCORES(NC), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .flush (flush),
        .arg_a (arg_a),
        .arg_b (arg_b),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        flush = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Cycles from the request cycle t to the done cycle.
    function automatic int exp_lat(input logic [31:0] b);
        int lat;
        lat = DW + 1;
`ifdef MUL_EARLY_EXIT_EN
        begin
            int m;
            m = -1;
            for (int i = 0; i < DW; i++) if (b[i]) m = i;
            if (m < 0) lat = 2;
            else if (m + 3 < DW + 1) lat = m + 3;
        end
`endif
        return lat;
    endfunction

    task automatic run_op(input int core, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r);
        int lat;
        bit got;
        req = '0;
        req[core] = 1'b1;
        arg_a[core*DW +: DW] = a;
        arg_b[core*DW +: DW] = b;
        tick();
        chk("gnt_onehot", 64'(gnt), 64'(4'b1 << core));
        chk("busy_run", 64'(busy), 64'd1);
        // Operands changed after grant must not disturb the result.
        arg_a[core*DW +: DW] = ~a;
        arg_b[core*DW +: DW] = b ^ 32'h5A5A_0001;
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (done != '0) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: core %0d got no done, required one", core);
        end else begin
            chk("done_onehot", 64'(done), 64'(4'b1 << core));
            chk("res", 64'(res), 64'(r));
            chk("latency", 64'(lat), 64'(exp_lat(b)));
        end
        req = '0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        tv[0] = '{1, 32'd7,         32'd6,         32'd42};
        tv[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tv[2] = '{2, 32'h8000_0000, 32'd2,         32'h0000_0000};
        tv[3] = '{3, 32'h1234_5678, 32'd0,         32'h0000_0000};
        tv[4] = '{0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF};
        tv[5] = '{2, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tv[6] = '{1, 32'd5,         32'd3,         32'd15};
        tv[7] = '{3, 32'd1000,      32'd1000,      32'd1000000};

        do_reset();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(res), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].core, tv[i].a, tv[i].b, tv[i].r);
        end

        // Round-robin: cores 0, 2, 3 hold requests continuously.
        begin
            int exp_own[4];
            int n_ev;
            int cyc;
            int last_cyc;
            exp_own = '{0, 2, 3, 0};
            do_reset();
            for (int i = 0; i < NC; i++) begin
                arg_a[i*DW +: DW] = 32'(i + 1);
                arg_b[i*DW +: DW] = 32'd10;
            end
            req = 4'b1101;
            n_ev = 0;
            cyc = 0;
            last_cyc = 0;
            for (int k = 0; k < 250 && n_ev < 4; k++) begin
                tick();
                cyc++;
                if (done != '0) begin
                    chk("rr_done", 64'(done), 64'(4'b1 << exp_own[n_ev]));
                    chk("rr_res", 64'(res), 64'((exp_own[n_ev] + 1) * 10));
                    if (n_ev > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'(exp_lat(32'd10) + 1));
                    last_cyc = cyc;
                    n_ev++;
                end
            end
            if (n_ev < 4) begin
                n_checks++;
                n_errors++;
                $display("FAIL rr_timeout: got %0d done pulses, required 4", n_ev);
            end
            req = '0;
        end

        // Owner flush mid-operation while core 2 waits.
        begin
            bit got;
            do_reset();
            arg_a[0*DW +: DW] = 32'd100;
            arg_b[0*DW +: DW] = 32'h8000_0001;
            arg_a[2*DW +: DW] = 32'd9;
            arg_b[2*DW +: DW] = 32'd9;
            req = 4'b0101;
            tick();
            chk("fl_gnt0", 64'(gnt), 64'b0001);
            for (int k = 0; k < 9; k++) tick();
            flush = 4'b0001;
            req   = 4'b0100;
            chk("fl_done_t10", 64'(done), 64'd0);
            tick();
            chk("fl_busy_t11", 64'(busy), 64'd0);
            chk("fl_done_t11", 64'(done), 64'd0);
            flush = '0;
            tick();
            chk("fl_gnt2_t12", 64'(gnt), 64'b0100);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                if (done != '0) got = 1'b1;
                else tick();
            end
            if (!got) begin
                n_checks++;
                n_errors++;
                $display("FAIL fl_timeout: core 2 got no done, required one");
            end else begin
                chk("fl_done2", 64'(done), 64'b0100);
                chk("fl_res2", 64'(res), 64'd81);
            end
            req = '0;
            tick();
        end

        // Reset in the middle of an operation.
        do_reset();
        arg_a[1*DW +: DW] = 32'd1;
        arg_b[1*DW +: DW] = 32'hFFFF_FFFF;
        req = 4'b0010;
        tick();
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        chk("mr_gnt", 64'(gnt), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_res", 64'(res), 64'd0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        chk("mr_gnt0", 64'(gnt), 64'b0001);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
